udma_evt_collector: RTL and testbench

UDMA_EVT_COLLECTOR -- requirements
Module: udma_evt_collector

---
 rtl/udma_pkg.sv | 15 +
 rtl/udma_evt_rr_arb.sv | 41 ++++
 rtl/udma_evt_collector.sv | 145 ++++++++++++++
 tb/tb_udma_evt_collector.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_pkg.sv
// Shared constants for the uDMA event collector: event id width and register map.
package udma_pkg;

  localparam int EVT_ID_WIDTH = 8;

  localparam logic [4:0] CFG_MASK_BASE  = 5'h00;
  localparam int         CFG_MASK_WORDS = 8;
  localparam logic [4:0] CFG_STATUS     = 5'h10;
  localparam logic [4:0] CFG_OVF_CNT    = 5'h11;

  localparam int STATUS_LOST_BIT = 0;

  typedef logic [EVT_ID_WIDTH-1:0] evt_id_t;

endpackage

// File: rtl/udma_evt_rr_arb.sv
// Round-robin arbiter: grants the first request at or above ptr, wrapping; ptr moves past each grant.
module udma_evt_rr_arb #(
  parameter int W = 32,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          srst,
  input  logic [W-1:0]  req,
  input  logic          en,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_reg;
  logic          found;

  // Scan from the highest offset down so the nearest request to ptr wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = W - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_reg) + k;
      if (idx >= W) idx = idx - W;
      if (req[idx]) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    gnt_valid = found & en;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_reg <= '0;
    end else if (gnt_valid) begin
      ptr_reg <= (gnt_idx == IW'(W - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/udma_evt_collector.sv
// Event collector: masked capture into pending bits, round-robin drain into an output FIFO.
// Optional 16-bit dropped-pulse counter at 0x11 enabled by macro UDMA_EVT_OVF_CNT_EN.
module udma_evt_collector
  import udma_pkg::*;
#(
  parameter int N_PERIPHS  = 8,
  parameter int N_EVT      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_i,
  input  logic [N_PERIPHS*N_EVT-1:0] evt_i,
  input  logic [31:0]                cfg_data_i,
  input  logic [4:0]                 cfg_addr_i,
  input  logic                       cfg_valid_i,
  input  logic                       cfg_rwn_i,
  output logic                       cfg_ready_o,
  output logic [31:0]                cfg_data_o,
  output logic                       evt_valid_o,
  output logic [EVT_ID_WIDTH-1:0]    evt_data_o,
  input  logic                       evt_ready_i
);

  localparam int N  = N_PERIPHS * N_EVT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  pending_reg;
  logic [N-1:0]  mask_reg;
  logic          lost_reg;
  evt_id_t       mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic          cfg_wr;
  logic          fifo_full;
  logic          fifo_pop;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  gnt_vec;
  logic [N-1:0]  capture;
  logic [N-1:0]  drop;
  logic [255:0]  mask_pad;

  assign cfg_wr    = cfg_valid_i & ~cfg_rwn_i;
  assign fifo_full = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_pop  = (count_reg != '0) & evt_ready_i;

  udma_evt_rr_arb #(.W(N)) u_arb (
    .clk       (sys_clk_i),
    .srst      (sys_rst_i),
    .req       (pending_reg),
    .en        (~fifo_full),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A pulse on the source being granted this cycle re-arms it rather than dropping.
  assign gnt_vec = gnt_valid ? (N'(1) << gnt_idx) : '0;
  assign capture = evt_i & mask_reg;
  assign drop    = capture & pending_reg & ~gnt_vec;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      pending_reg <= '0;
      lost_reg    <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      pending_reg <= (pending_reg & ~gnt_vec) | capture;
      if (|drop) begin
        lost_reg <= 1'b1;
      end else if (cfg_wr && cfg_addr_i == CFG_STATUS && cfg_data_i[STATUS_LOST_BIT]) begin
        lost_reg <= 1'b0;
      end
      if (gnt_valid) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(gnt_valid) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (gnt_valid) mem[wr_ptr_reg] <= EVT_ID_WIDTH'(gnt_idx);
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
        mask_reg[gi] <= 1'b1;
      end else if (cfg_wr && cfg_addr_i == CFG_MASK_BASE + 5'(gi / 32)) begin
        mask_reg[gi] <= cfg_data_i[gi % 32];
      end
    end
  end

`ifdef UDMA_EVT_OVF_CNT_EN
  logic [15:0] ovf_cnt_reg;
  logic [8:0]  drop_cnt;
  logic [16:0] ovf_sum;

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < N; i++) drop_cnt = drop_cnt + 9'(drop[i]);
    ovf_sum = 17'(ovf_cnt_reg) + 17'(drop_cnt);
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      ovf_cnt_reg <= '0;
    end else if (cfg_wr && cfg_addr_i == CFG_OVF_CNT) begin
      ovf_cnt_reg <= '0;
    end else begin
      ovf_cnt_reg <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end
`endif

  always_comb begin
    mask_pad        = '0;
    mask_pad[N-1:0] = mask_reg;
  end

  always_comb begin
    cfg_data_o = '0;
    if (cfg_valid_i && cfg_rwn_i) begin
      if (cfg_addr_i[4:3] == 2'b00) begin
        cfg_data_o = mask_pad[{cfg_addr_i[2:0], 5'b0} +: 32];
      end else if (cfg_addr_i == CFG_STATUS) begin
        cfg_data_o = {16'h0, 8'(count_reg), 7'h0, lost_reg};
`ifdef UDMA_EVT_OVF_CNT_EN
      end else if (cfg_addr_i == CFG_OVF_CNT) begin
        cfg_data_o = {16'h0, ovf_cnt_reg};
`endif
      end
    end
  end

  assign cfg_ready_o = cfg_valid_i;
  assign evt_valid_o = (count_reg != '0);
  assign evt_data_o  = evt_valid_o ? mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_udma_evt_collector.sv
// Self-checking bench: register table, directed corner sequences, random traffic against a queue model.
module tb_udma_evt_collector;

  localparam int N     = 32;
  localparam int DEPTH = 8;

  logic          sys_clk_i = 1'b0;
  logic          sys_rst_i;
  logic [N-1:0]  evt_i;
  logic [31:0]   cfg_data_i;
  logic [4:0]    cfg_addr_i;
  logic          cfg_valid_i;
  logic          cfg_rwn_i;
  logic          cfg_ready_o;
  logic [31:0]   cfg_data_o;
  logic          evt_valid_o;
  logic [7:0]    evt_data_o;
  logic          evt_ready_i;

  int checks = 0;
  int failures = 0;

  udma_evt_collector dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_i   (sys_rst_i),
    .evt_i       (evt_i),
    .cfg_data_i  (cfg_data_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_rwn_i   (cfg_rwn_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_data_o  (cfg_data_o),
    .evt_valid_o (evt_valid_o),
    .evt_data_o  (evt_data_o),
    .evt_ready_i (evt_ready_i)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  // Reference model state: plain arrays and a queue.
  bit m_pending [N];
  bit m_mask    [N];
  int m_q [$];
  int m_ptr;
  bit m_lost;
  int m_ovf;
  int got [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = '0;
    if (a < 8) begin
      for (int b = 0; b < 32; b++) if (a * 32 + b < N) v[b] = m_mask[a * 32 + b];
    end else if (a == 5'h10) begin
      v = (m_q.size() << 8) | 32'(m_lost);
    end else if (a == 5'h11) begin
`ifdef UDMA_EVT_OVF_CNT_EN
      v = 32'(m_ovf);
`endif
    end
    return v;
  endfunction

  task automatic model_step();
    int g;
    int drops;
    g = -1;
    drops = 0;
    if (sys_rst_i) begin
      foreach (m_pending[i]) begin m_pending[i] = 0; m_mask[i] = 1; end
      m_q.delete();
      m_ptr = 0; m_lost = 0; m_ovf = 0;
      return;
    end
    if (m_q.size() < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        if (m_pending[(m_ptr + k) % N]) begin g = (m_ptr + k) % N; break; end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (evt_i[i] && m_mask[i] && m_pending[i] && i != g) drops++;
    end
    for (int i = 0; i < N; i++) begin
      if (i == g) m_pending[i] = 0;
      if (evt_i[i] && m_mask[i]) m_pending[i] = 1;
    end
    if (drops > 0) m_lost = 1;
    else if (cfg_valid_i && !cfg_rwn_i && cfg_addr_i == 5'h10 && cfg_data_i[0]) m_lost = 0;
    if (cfg_valid_i && !cfg_rwn_i && cfg_addr_i == 5'h11) m_ovf = 0;
    else m_ovf = (m_ovf + drops > 65535) ? 65535 : m_ovf + drops;
    if (cfg_valid_i && !cfg_rwn_i && cfg_addr_i < 8) begin
      for (int b = 0; b < 32; b++) if (cfg_addr_i * 32 + b < N) m_mask[cfg_addr_i * 32 + b] = cfg_data_i[b];
    end
    if (m_q.size() > 0 && evt_ready_i) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      m_ptr = (g + 1) % N;
    end
  endtask

  // One clock cycle: compare against the model with current inputs, then advance both.
  task automatic tick();
    #1;
    chk("evt_valid", 32'(evt_valid_o), 32'(m_q.size() > 0));
    chk("evt_data", 32'(evt_data_o), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
    chk("cfg_ready", 32'(cfg_ready_o), 32'(cfg_valid_i));
    chk("cfg_data", cfg_data_o, (cfg_valid_i && cfg_rwn_i) ? model_read(cfg_addr_i) : 32'h0);
    model_step();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    cfg_valid_i = 1; cfg_rwn_i = 1; cfg_addr_i = a;
    #1;
    chk(nm, cfg_data_o, exp);
    tick();
    cfg_valid_i = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg_valid_i = 1; cfg_rwn_i = 0; cfg_addr_i = a; cfg_data_i = d;
    tick();
    cfg_valid_i = 0; cfg_data_i = '0;
  endtask

  task automatic collect(input int max_cycles);
    got.delete();
    for (int c = 0; c < max_cycles; c++) begin
      if (evt_valid_o && evt_ready_i) got.push_back(int'(evt_data_o));
      tick();
    end
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic        rwn;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [15];

  initial begin
    vecs = '{
      '{5'h00, 1'b1, 32'h0,        32'hFFFFFFFF},
      '{5'h00, 1'b0, 32'h12345678, 32'h0},
      '{5'h00, 1'b1, 32'h0,        32'h12345678},
      '{5'h01, 1'b1, 32'h0,        32'h0},
      '{5'h01, 1'b0, 32'hFFFFFFFF, 32'h0},
      '{5'h01, 1'b1, 32'h0,        32'h0},
      '{5'h07, 1'b1, 32'h0,        32'h0},
      '{5'h12, 1'b0, 32'h0000FFFF, 32'h0},
      '{5'h12, 1'b1, 32'h0,        32'h0},
      '{5'h1F, 1'b1, 32'h0,        32'h0},
      '{5'h10, 1'b1, 32'h0,        32'h0},
      '{5'h11, 1'b0, 32'h5,        32'h0},
      '{5'h11, 1'b1, 32'h0,        32'h0},
      '{5'h00, 1'b0, 32'hFFFFFFFF, 32'h0},
      '{5'h00, 1'b1, 32'h0,        32'hFFFFFFFF}
    };

    sys_rst_i = 1; evt_i = '0; cfg_data_i = '0; cfg_addr_i = '0;
    cfg_valid_i = 0; cfg_rwn_i = 1; evt_ready_i = 1;
    @(posedge sys_clk_i); #1;
    tick(); tick();
    sys_rst_i = 0;
    chk("reset_valid", 32'(evt_valid_o), 32'h0);
    chk("reset_data", 32'(evt_data_o), 32'h0);
    rd(5'h10, 32'h0, "reset_status");

    foreach (vecs[i]) begin
      cfg_valid_i = 1; cfg_rwn_i = vecs[i].rwn; cfg_addr_i = vecs[i].addr; cfg_data_i = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d", i), cfg_data_o, vecs[i].exp);
      tick();
    end
    cfg_valid_i = 0; cfg_data_i = '0;

    // Single pulse latency: visible two cycles later for exactly one cycle.
    evt_i = N'(1) << 5;
    tick();
    evt_i = '0;
    chk("lat_c1_valid", 32'(evt_valid_o), 32'h0);
    tick();
    chk("lat_c2_valid", 32'(evt_valid_o), 32'h1);
    chk("lat_c2_data", 32'(evt_data_o), 32'h5);
    tick();
    chk("lat_c3_valid", 32'(evt_valid_o), 32'h0);

    // Pointer now sits at 6; reset it so the 1,3,6 order starts from ptr=0.
    sys_rst_i = 1; tick(); sys_rst_i = 0;
    evt_i = (N'(1) << 1) | (N'(1) << 3) | (N'(1) << 6);
    tick();
    evt_i = '0;
    collect(8);
    chk("rr_count", 32'(got.size()), 32'h3);
    if (got.size() == 3) begin
      chk("rr_0", 32'(got[0]), 32'h1);
      chk("rr_1", 32'(got[1]), 32'h3);
      chk("rr_2", 32'(got[2]), 32'h6);
    end
    // ptr at 7: source 8 must win over source 2.
    evt_i = (N'(1) << 2) | (N'(1) << 8);
    tick();
    evt_i = '0;
    collect(6);
    chk("ptr_count", 32'(got.size()), 32'h2);
    if (got.size() == 2) chk("ptr_first", 32'(got[0]), 32'h8);

    // Backpressure: 10 sources, FIFO holds 8, two stay pending.
    evt_ready_i = 0;
    for (int i = 10; i < 20; i++) evt_i[i] = 1'b1;
    tick();
    evt_i = '0;
    repeat (12) tick();
    rd(5'h10, 32'h0000_0800, "full_status");
    evt_ready_i = 1;
    collect(20);
    chk("bp_count", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size() && i < 10; i++) chk($sformatf("bp_%0d", i), 32'(got[i]), 32'(10 + i));
    rd(5'h10, 32'h0, "bp_lost");

    // Loss with FIFO full: second pulse on pending source 2 is dropped.
    evt_ready_i = 0;
    for (int i = 20; i < 28; i++) evt_i[i] = 1'b1;
    tick();
    evt_i = '0;
    repeat (12) tick();
    evt_i = N'(1) << 2; tick();
    evt_i = N'(1) << 2; tick();
    evt_i = '0;
    rd(5'h10, 32'h0000_0801, "lost_set");
`ifdef UDMA_EVT_OVF_CNT_EN
    rd(5'h11, 32'h1, "ovf_cnt");
    wr(5'h11, 32'h0);
    rd(5'h11, 32'h0, "ovf_clear");
`else
    rd(5'h11, 32'h0, "ovf_absent");
`endif
    wr(5'h10, 32'h1);
    rd(5'h10, 32'h0000_0800, "lost_clear");
    evt_ready_i = 1;
    collect(16);
    chk("loss_count", 32'(got.size()), 32'd9);
    if (got.size() == 9) chk("loss_last", 32'(got[8]), 32'h2);

    // Masked source never emits; reset mid-queue discards.
    wr(5'h00, 32'hFFFF_FFFE);
    evt_i = N'(1); tick(); evt_i = '0;
    collect(5);
    chk("mask_none", 32'(got.size()), 32'h0);
    evt_ready_i = 0;
    evt_i = (N'(1) << 4) | (N'(1) << 5) | (N'(1) << 6);
    tick();
    evt_i = '0;
    repeat (5) tick();
    rd(5'h10, 32'h0000_0300, "queued3");
    sys_rst_i = 1; tick(); sys_rst_i = 0;
    chk("rst_mid_valid", 32'(evt_valid_o), 32'h0);
    chk("rst_mid_data", 32'(evt_data_o), 32'h0);
    evt_ready_i = 1;
    collect(6);
    chk("rst_mid_none", 32'(got.size()), 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) evt_i[i] = ($urandom_range(15) == 0);
      evt_ready_i = ($urandom_range(3) != 0);
      sys_rst_i = ($urandom_range(499) == 0);
      cfg_valid_i = ($urandom_range(7) == 0);
      cfg_rwn_i = ($urandom_range(2) != 0);
      case ($urandom_range(5))
        0, 1:    cfg_addr_i = 5'($urandom_range(7));
        2:       cfg_addr_i = 5'h10;
        3:       cfg_addr_i = 5'h11;
        default: cfg_addr_i = 5'($urandom_range(31));
      endcase
      cfg_data_i = (cfg_addr_i < 8) ? ($urandom() | 32'hFFF0_FFF0) : $urandom();
      tick();
    end
    sys_rst_i = 0; cfg_valid_i = 0; evt_i = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
